// File: rtl/prefetch_pkg.sv
// Shared constants, bus FSM encoding and physical-address helper for the instruction prefetch unit.
package prefetch_pkg;

    localparam logic [3:0] BUS_IDLE  = 4'hF;
    localparam logic [3:0] BUS_FETCH = 4'h9;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } bus_fsm_t;

    // Segment base times 16 plus offset, wrapping at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] ps, input logic [15:0] off);
        return {ps, 4'h0} + {4'h0, off};
    endfunction

endpackage

// File: rtl/byte_ring_fifo.sv
// Byte ring buffer: 0/1/2-byte push, 0..PEEK_BYTES pop per cycle, clear, and a window onto the oldest bytes.
module byte_ring_fifo
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PEEK_BYTES = 4,
    parameter int unsigned LW         = $clog2(DEPTH + 1),
    parameter int unsigned PW         = $clog2(PEEK_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [1:0]              push_count,
    input  logic [15:0]             push_data,
    input  logic [PW-1:0]           pop_count,
    output logic [8*PEEK_BYTES-1:0] peek_data,
    output logic [LW-1:0]           level,
    output logic                    empty,
    output logic                    full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] pop_eff;

    // Over-pop is a caller bug; clamp so the ring never underflows.
    always_comb begin
        pop_eff = (LW'(pop_count) > level) ? level : LW'(pop_count);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_count != 2'd0) mem[wr_ptr] <= push_data[7:0];
            if (push_count == 2'd2) mem[wr_ptr + AW'(1)] <= push_data[15:8];
            wr_ptr <= wr_ptr + AW'(push_count);
            rd_ptr <= rd_ptr + AW'(pop_eff);
            level  <= level + LW'(push_count) - pop_eff;
        end
    end

    // Bytes beyond the current level read as zero so stale ring contents never leak out.
    always_comb begin
        peek_data = '0;
        for (int i = 0; i < int'(PEEK_BYTES); i++) begin
            if (LW'(i) < level) peek_data[8*i +: 8] = mem[rd_ptr + AW'(i)];
        end
    end

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    pop_within_level: assert property (@(posedge clk) disable iff (reset || clear)
                                       LW'(pop_count) <= level);

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: owns PS/PFP, runs the bus read handshake and feeds the byte ring.
module instr_prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PEEK_BYTES = 4,
    parameter int unsigned LW         = $clog2(DEPTH + 1),
    parameter int unsigned PW         = $clog2(PEEK_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [15:0]             flush_ps,
    input  logic [15:0]             flush_pc,
    input  logic [PW-1:0]           pop_count,
    output logic [8*PEEK_BYTES-1:0] peek_data,
    output logic [LW-1:0]           level,
    output logic                    empty,
    output logic                    full,
    output logic                    bus_req,
    output logic [19:0]             bus_addr,
    output logic [3:0]              bus_status,
    input  logic                    bus_ready_n,
    input  logic [15:0]             bus_data,
    output logic [15:0]             pfp
);

    bus_fsm_t      state_q;
    bus_fsm_t      state_d;
    logic [15:0]   ps_q;
    logic [15:0]   pfp_q;
    logic [1:0]    need;
    logic [LW-1:0] free_bytes;
    logic          space_ok;
    logic          complete;
    logic [1:0]    push_count;
    logic [15:0]   push_data;

    // An odd offset fetches only the high byte, realigning the next fetch to a word boundary.
    always_comb begin
        need       = pfp_q[0] ? 2'd1 : 2'd2;
        free_bytes = LW'(DEPTH) - level;
        space_ok   = (free_bytes >= LW'(need));
        complete   = (state_q == FETCH) && !bus_ready_n && !flush;
        push_count = complete ? need : 2'd0;
        push_data  = pfp_q[0] ? {8'h00, bus_data[15:8]} : bus_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!flush && space_ok) state_d = FETCH;
            FETCH:   if (flush || !bus_ready_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req    = (state_q == FETCH);
        bus_status = bus_req ? BUS_FETCH : BUS_IDLE;
        bus_addr   = phys_addr(ps_q, pfp_q);
        pfp        = pfp_q;
    end

    // Fetch pointer: redirect on flush, advance by bytes accepted; PS only changes on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q  <= 16'hFFFF;
            pfp_q <= 16'h0000;
        end else if (flush) begin
            ps_q  <= flush_ps;
            pfp_q <= flush_pc;
        end else if (complete) begin
            pfp_q <= pfp_q + 16'(need);
        end
    end

    byte_ring_fifo #(
        .DEPTH      (DEPTH),
        .PEEK_BYTES (PEEK_BYTES),
        .LW         (LW),
        .PW         (PW)
    ) u_ring (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push_count (push_count),
        .push_data  (push_data),
        .pop_count  (pop_count),
        .peek_data  (peek_data),
        .level      (level),
        .empty      (empty),
        .full       (full)
    );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: byte-queue reference model compared every cycle, directed and random stimulus.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 8;
    localparam int PEEK  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] flush_ps;
    logic [15:0] flush_pc;
    logic [2:0]  pop_count;
    logic [31:0] peek_data;
    logic [3:0]  level;
    logic        empty;
    logic        full;
    logic        bus_req;
    logic [19:0] bus_addr;
    logic [3:0]  bus_status;
    logic        bus_ready_n;
    logic [15:0] bus_data;
    logic [15:0] pfp;

    int errors = 0;
    int checks = 0;

    // Reference model: the queue contents, segment, fetch offset and whether a bus cycle is open.
    logic [7:0]  q[$];
    logic [15:0] m_ps;
    logic [15:0] m_pfp;
    logic        m_busy;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    instr_prefetch_unit #(.DEPTH(DEPTH), .PEEK_BYTES(PEEK)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .flush_ps    (flush_ps),
        .flush_pc    (flush_pc),
        .pop_count   (pop_count),
        .peek_data   (peek_data),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_status  (bus_status),
        .bus_ready_n (bus_ready_n),
        .bus_data    (bus_data),
        .pfp         (pfp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int n;
        int need;
        if (reset) begin
            q.delete();
            m_ps    = 16'hFFFF;
            m_pfp   = 16'h0000;
            m_busy  = 1'b0;
            m_valid = 1'b1;
        end else if (flush) begin
            q.delete();
            m_ps   = flush_ps;
            m_pfp  = flush_pc;
            m_busy = 1'b0;
        end else begin
            need = m_pfp[0] ? 1 : 2;
            n    = (int'(pop_count) > q.size()) ? q.size() : int'(pop_count);
            if (m_busy && !bus_ready_n) begin
                if (m_pfp[0]) begin
                    q.push_back(bus_data[15:8]);
                end else begin
                    q.push_back(bus_data[7:0]);
                    q.push_back(bus_data[15:8]);
                end
                m_pfp  = m_pfp + 16'(need);
                m_busy = 1'b0;
            end else if (!m_busy && (DEPTH - q.size() >= need)) begin
                m_busy = 1'b1;
            end
            repeat (n) void'(q.pop_front());
        end
    endtask

    task automatic compare_model();
        logic [31:0] ep;
        logic [19:0] ea;
        ep = '0;
        for (int i = 0; i < PEEK; i++) begin
            if (i < q.size()) ep[8*i +: 8] = q[i];
        end
        ea = {m_ps, 4'h0} + {4'h0, m_pfp};
        chk("level",      32'(level),      32'(q.size()));
        chk("empty",      32'(empty),      32'(q.size() == 0));
        chk("full",       32'(full),       32'(q.size() == DEPTH));
        chk("bus_req",    32'(bus_req),    32'(m_busy));
        chk("bus_status", 32'(bus_status), m_busy ? 32'h9 : 32'hF);
        chk("bus_addr",   32'(bus_addr),   32'(ea));
        chk("pfp",        32'(pfp),        32'(m_pfp));
        chk("peek_data",  peek_data,       ep);
    endtask

    always @(negedge clk) begin
        if (m_valid) compare_model();
    end

    task automatic step(input logic rst, input logic fl, input logic [15:0] fps, input logic [15:0] fpc,
                        input logic [2:0] pop, input logic rdy_n, input logic [15:0] data);
        reset       = rst;
        flush       = fl;
        flush_ps    = fps;
        flush_pc    = fpc;
        pop_count   = pop;
        bus_ready_n = rdy_n;
        bus_data    = data;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run(input logic [2:0] pop, input logic rdy_n, input logic [15:0] data);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, pop, rdy_n, data);
    endtask

    initial begin
        int r;
        int maxpop;
        logic [15:0] fpc;

        // Reset state
        step(1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0);
        step(1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0);
        chk("rst_level",  32'(level),      32'd0);
        chk("rst_empty",  32'(empty),      32'd1);
        chk("rst_req",    32'(bus_req),    32'd0);
        chk("rst_status", 32'(bus_status), 32'hF);
        chk("rst_peek",   peek_data,       32'h0);

        // First fetch at the reset vector, then fill to capacity with no pops
        run(3'd0, 1'b0, 16'hBBAA);
        chk("first_addr", 32'(bus_addr), 32'h000FFFF0);
        chk("first_req",  32'(bus_req),  32'd1);
        run(3'd0, 1'b0, 16'hBBAA);
        chk("first_peek",  peek_data,   32'h0000BBAA);
        chk("first_pfp",   32'(pfp),    32'd2);
        chk("first_level", 32'(level),  32'd2);
        repeat (10) run(3'd0, 1'b0, 16'hBBAA);
        chk("fill_level",  32'(level),      32'd8);
        chk("fill_full",   32'(full),       32'd1);
        chk("fill_req",    32'(bus_req),    32'd0);
        chk("fill_status", 32'(bus_status), 32'hF);
        chk("fill_pfp",    32'(pfp),        32'd8);

        // Flush to an odd offset: single high-byte fetch, then word-aligned again
        step(1'b0, 1'b1, 16'h1000, 16'h0005, 3'd0, 1'b0, 16'hBBAA);
        chk("flush_level", 32'(level),   32'd0);
        chk("flush_req",   32'(bus_req), 32'd0);
        run(3'd0, 1'b0, 16'h3412);
        chk("odd_addr", 32'(bus_addr), 32'h00010005);
        run(3'd0, 1'b0, 16'h3412);
        chk("odd_peek",  peek_data,  32'h00000034);
        chk("odd_level", 32'(level), 32'd1);
        run(3'd0, 1'b0, 16'h5678);
        chk("even_addr", 32'(bus_addr), 32'h00010006);
        run(3'd0, 1'b0, 16'h5678);
        chk("three_peek", peek_data, 32'h00567834);

        // Pop two while a word lands: level unchanged, old byte2 becomes byte0
        run(3'd0, 1'b0, 16'h9ABC);
        run(3'd2, 1'b0, 16'h9ABC);
        chk("pp_level", 32'(level), 32'd3);
        chk("pp_peek",  peek_data,  32'h009ABC56);

        // Offset wrap inside a segment
        step(1'b0, 1'b1, 16'h2000, 16'hFFFE, 3'd0, 1'b1, 16'h0);
        run(3'd0, 1'b1, 16'h0);
        chk("wrap_addr0", 32'(bus_addr), 32'h0002FFFE);
        run(3'd0, 1'b0, 16'h1111);
        chk("wrap_pfp", 32'(pfp), 32'd0);
        run(3'd0, 1'b1, 16'h0);
        chk("wrap_addr1", 32'(bus_addr), 32'h00020000);

        // Flush aborts an outstanding fetch; the late ready pushes nothing
        run(3'd0, 1'b1, 16'h0);
        chk("abort_pre_req", 32'(bus_req), 32'd1);
        step(1'b0, 1'b1, 16'h2000, 16'h0000, 3'd0, 1'b1, 16'h0);
        chk("abort_req",   32'(bus_req), 32'd0);
        chk("abort_level", 32'(level),   32'd0);
        run(3'd0, 1'b0, 16'h2222);
        chk("late_level", 32'(level), 32'd0);

        // Randomised traffic checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            r      = $urandom_range(0, 99);
            maxpop = (q.size() < PEEK) ? q.size() : PEEK;
            fpc    = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (16'hFFF0 + 16'($urandom_range(0, 15)));
            step(r < 1, (r >= 1) && (r < 5), 16'($urandom), fpc,
                 ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, maxpop)) : 3'd0,
                 ($urandom_range(0, 2) == 0), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
